// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: data width, access-size
// encodings, response-slot states and the lane-steering helpers.
package dmem_responder_pkg;

    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;

    typedef enum logic [1:0] {
        MEM_SIZE_B = 2'b00,
        MEM_SIZE_H = 2'b01,
        MEM_SIZE_W = 2'b10,
        MEM_SIZE_R = 2'b11
    } mem_size_e;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_e;

    function automatic logic [BE_W-1:0] byte_enables(input mem_size_e size, input logic [1:0] lane);
        case (size)
            MEM_SIZE_B: return BE_W'(4'b0001) << lane;
            MEM_SIZE_H: return BE_W'(4'b0011) << lane;
            default:    return '1;
        endcase
    endfunction

    // Narrow store data is replicated so whichever lanes are enabled see it.
    function automatic logic [DATA_W-1:0] store_lanes(input mem_size_e size, input logic [DATA_W-1:0] wdata);
        case (size)
            MEM_SIZE_B: return {4{wdata[7:0]}};
            MEM_SIZE_H: return {2{wdata[15:0]}};
            default:    return wdata;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] load_extend(input mem_size_e size, input logic [1:0] lane,
                                                      input logic is_unsigned, input logic [DATA_W-1:0] word);
        logic [DATA_W-1:0] shifted;
        shifted = word >> {lane, 3'b000};
        case (size)
            MEM_SIZE_B: return {{24{shifted[7] & ~is_unsigned}}, shifted[7:0]};
            MEM_SIZE_H: return {{16{shifted[15] & ~is_unsigned}}, shifted[15:0]};
            default:    return word;
        endcase
    endfunction

endpackage

// File: rtl/dmem_sram.sv
// Word-organised data RAM: byte-enable write port and registered read port
// sharing one index (one request per cycle).
module dmem_sram
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic              re,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // NOTE: no reset on the array or read register; RAM macros cannot be
    // cleared in one cycle and consumers never see rdata before a read.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        if (re) rdata <= mem[idx];
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: valid/ready request port, one-deep
// response slot, lane-aligned extended loads and byte-enabled stores.
// Define DMEM_ERR_CHECK_EN for misalignment/reserved-size/range error responses.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    mem_size_e         size;
    mem_size_e         eff_size;
    logic [1:0]        eff_lane;
    logic              req_err;
    logic              accept;
    slot_e             slot_q;
    slot_e             slot_d;
    logic [DATA_W-1:0] sram_rdata;

    mem_size_e         cap_size;
    logic [1:0]        cap_lane;
    logic              cap_unsigned;
    logic              cap_load;
    logic              cap_err;

    assign size = mem_size_e'(req_size);

`ifdef DMEM_ERR_CHECK_EN
    always_comb begin
        eff_size = size;
        eff_lane = req_addr[1:0];
        req_err  = (size == MEM_SIZE_R)
                || (size == MEM_SIZE_H && req_addr[0])
                || (size == MEM_SIZE_W && req_addr[1:0] != 2'b00)
                || (req_addr[31:2] >= 30'(DEPTH_WORDS));
    end
`else
    // Address bits above the index are ignored, so accesses wrap.
    logic unused_addr;
    assign unused_addr = ^req_addr[31:IDX_W+2];

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        req_err  = 1'b0;
        eff_size = size;
        eff_lane = req_addr[1:0];
        case (size)
            MEM_SIZE_H: eff_lane = {req_addr[1], 1'b0};
            MEM_SIZE_W,
            MEM_SIZE_R: begin
                eff_size = MEM_SIZE_W;
                eff_lane = 2'b00;
            end
            default: ;
        endcase
    end
`endif

    // Gating with rst keeps a store presented during reset out of the RAM.
    assign req_ready = (slot_q == SLOT_EMPTY) || rsp_ready;
    assign accept    = req_valid && req_ready && rst;

    dmem_sram #(.DEPTH_WORDS(DEPTH_WORDS)) u_sram (
        .clk   (clk),
        .we    (accept && req_write && !req_err),
        .be    (byte_enables(eff_size, eff_lane)),
        .re    (accept && !req_write && !req_err),
        .idx   (req_addr[IDX_W+1:2]),
        .wdata (store_lanes(eff_size, req_wdata)),
        .rdata (sram_rdata)
    );

    always_comb begin
        slot_d = slot_q;
        if (accept)         slot_d = SLOT_FULL;
        else if (rsp_ready) slot_d = SLOT_EMPTY;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_q       <= SLOT_EMPTY;
            cap_size     <= MEM_SIZE_B;
            cap_lane     <= 2'b00;
            cap_unsigned <= 1'b0;
            cap_load     <= 1'b0;
            cap_err      <= 1'b0;
        end else begin
            slot_q <= slot_d;
            if (accept) begin
                cap_size     <= eff_size;
                cap_lane     <= eff_lane;
                cap_unsigned <= req_unsigned;
                cap_load     <= !req_write && !req_err;
                cap_err      <= req_err;
            end
        end
    end

    // The RAM read register only moves on accept, so held responses stay stable.
    assign rsp_valid = (slot_q == SLOT_FULL);
    assign rsp_error = cap_err;
    assign rsp_rdata = cap_load ? load_extend(cap_size, cap_lane, cap_unsigned, sram_rdata) : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vectors, stall, back-to-back,
// reset-drop and randomized traffic against a byte-level memory model.
module tb_dmem_responder;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic        req_unsigned = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_error    (rsp_error)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  s;
        logic        u;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] model_mem [DEPTH];
    rsp_t        exp_q [$];
    vec_t        vecs [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference behaviour: memory as bytes, accesses as byte counts and offsets.
    function automatic rsp_t model_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                                          input logic [1:0] s, input logic u);
        rsp_t        r;
        int          nbytes;
        int          off;
        int unsigned widx;
        logic [31:0] val;
        r.rdata = '0;
        r.err   = 1'b0;
        nbytes  = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
`ifdef DMEM_ERR_CHECK_EN
        r.err = (s == 2'd3) || (a % nbytes != 0) || (a / 4 >= DEPTH);
        off   = int'(a % 4);
`else
        off   = int'(a % 4) / nbytes * nbytes;
`endif
        if (r.err) return r;
        widx = (a / 4) % DEPTH;
        if (w) begin
            for (int k = 0; k < nbytes; k++) model_mem[widx][8*(off+k) +: 8] = d[8*k +: 8];
        end else begin
            val = '0;
            for (int k = 0; k < nbytes; k++) val[8*k +: 8] = model_mem[widx][8*(off+k) +: 8];
            if (!u && nbytes < 4 && val[8*nbytes-1]) begin
                for (int k = nbytes; k < 4; k++) val[8*k +: 8] = 8'hFF;
            end
            r.rdata = val;
        end
        return r;
    endfunction

    // One clock cycle, entered and left at a falling edge.
    task automatic cycle(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] s, input logic u, input logic rr);
        bit   was_full;
        rsp_t e;
        req_valid = v; req_write = w; req_addr = a; req_wdata = d;
        req_size = s; req_unsigned = u; rsp_ready = rr;
        #1;
        was_full = exp_q.size() != 0;
        check("rsp_valid", 32'(rsp_valid), 32'(was_full));
        check("req_ready", 32'(req_ready), 32'(!was_full || rr));
        if (was_full && rr) begin
            e = exp_q.pop_front();
            check("rsp_rdata", rsp_rdata, e.rdata);
            check("rsp_error", 32'(rsp_error), 32'(e.err));
        end
        if (v && (!was_full || rr)) exp_q.push_back(model_access(w, a, d, s, u));
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic [1:0] s, input logic u, input logic [31:0] er, input logic ee);
        vec_t v;
        v.w = w; v.a = a; v.d = d; v.s = s; v.u = u; v.exp_rdata = er; v.exp_err = ee;
        return v;
    endfunction

    initial begin
        logic [31:0] a;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_rsp_error", 32'(rsp_error), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Directed vectors
        vecs.push_back(mk(1, 32'h10, 32'hDEADBEEF, 2'd2, 0, 32'h0,        0));
        vecs.push_back(mk(0, 32'h13, 32'h0,        2'd0, 0, 32'hFFFFFFDE, 0));
        vecs.push_back(mk(0, 32'h13, 32'h0,        2'd0, 1, 32'h000000DE, 0));
        vecs.push_back(mk(1, 32'h20, 32'hA5A55A5A, 2'd2, 0, 32'h0,        0));
        vecs.push_back(mk(1, 32'h22, 32'hABCD1234, 2'd1, 0, 32'h0,        0));
        vecs.push_back(mk(0, 32'h20, 32'h0,        2'd2, 0, 32'h12345A5A, 0));
        vecs.push_back(mk(0, 32'h22, 32'h0,        2'd1, 0, 32'h00001234, 0));
        vecs.push_back(mk(0, 32'h10, 32'h0,        2'd1, 0, 32'hFFFFBEEF, 0));
        vecs.push_back(mk(0, 32'h12, 32'h0,        2'd1, 1, 32'h0000DEAD, 0));
        vecs.push_back(mk(1, 32'h11, 32'h00000080, 2'd0, 0, 32'h0,        0));
        vecs.push_back(mk(0, 32'h11, 32'h0,        2'd0, 0, 32'hFFFFFF80, 0));
        vecs.push_back(mk(0, 32'h10, 32'h0,        2'd2, 0, 32'hDEAD80EF, 0));
        vecs.push_back(mk(1, 32'h00, 32'hCAFEF00D, 2'd2, 0, 32'h0,        0));
`ifdef DMEM_ERR_CHECK_EN
        vecs.push_back(mk(0, 32'h22,        32'h0,        2'd2, 0, 32'h0,        1));
        vecs.push_back(mk(1, 32'(DEPTH*4),  32'h11111111, 2'd2, 0, 32'h0,        1));
        vecs.push_back(mk(0, 32'h00,        32'h0,        2'd2, 0, 32'hCAFEF00D, 0));
        vecs.push_back(mk(0, 32'h21,        32'h0,        2'd1, 0, 32'h0,        1));
        vecs.push_back(mk(0, 32'h20,        32'h0,        2'd3, 0, 32'h0,        1));
`else
        vecs.push_back(mk(0, 32'h22,        32'h0,        2'd2, 0, 32'h12345A5A, 0));
        vecs.push_back(mk(1, 32'(DEPTH*4),  32'h11111111, 2'd2, 0, 32'h0,        0));
        vecs.push_back(mk(0, 32'h00,        32'h0,        2'd2, 0, 32'h11111111, 0));
        vecs.push_back(mk(0, 32'h23,        32'h0,        2'd1, 0, 32'h00001234, 0));
        vecs.push_back(mk(0, 32'h21,        32'h0,        2'd3, 0, 32'h12345A5A, 0));
`endif
        foreach (vecs[i]) begin
            cycle(1, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].s, vecs[i].u, 1);
            check($sformatf("vec%0d_valid", i), 32'(rsp_valid), 32'd1);
            check($sformatf("vec%0d_rdata", i), rsp_rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d_error", i), 32'(rsp_error), 32'(vecs[i].exp_err));
        end
        cycle(0, 0, 0, 0, 0, 0, 1);

        // Stall: held load response, store waiting behind it
        cycle(1, 0, 32'h10, 32'h0, 2'd2, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 32'h10, 32'h0BADF00D, 2'd2, 0, 0);
            check("stall_req_ready", 32'(req_ready), 32'd0);
            check("stall_rsp_rdata", rsp_rdata, 32'hDEAD80EF);
        end
        cycle(1, 0, 32'h10, 32'h0, 2'd2, 0, 1);
        check("stall_no_write", rsp_rdata, 32'hDEAD80EF);
        cycle(1, 1, 32'h10, 32'h0BADF00D, 2'd2, 0, 1);
        cycle(1, 0, 32'h10, 32'h0, 2'd2, 0, 1);
        check("stall_after_write", rsp_rdata, 32'h0BADF00D);
        cycle(0, 0, 0, 0, 0, 0, 1);

        // Initialise the words used by the remaining traffic
        for (int i = 0; i < 64; i++) cycle(1, 1, 32'(i * 4), $urandom, 2'd2, 0, 1);

        // Eight back-to-back loads, one response per cycle
        for (int i = 0; i < 8; i++) begin
            cycle(1, 0, 32'(i * 4), 32'h0, 2'd2, 0, 1);
            check($sformatf("b2b_valid%0d", i), 32'(rsp_valid), 32'd1);
        end
        cycle(0, 0, 0, 0, 0, 0, 1);

        // Randomized traffic with random back-pressure and occasional wrap/range addresses
        for (int i = 0; i < 800; i++) begin
            a = (32'($urandom_range(0, 63)) << 2) | ($urandom & 32'h3);
            if ($urandom_range(0, 7) == 0) a[31:12] = 20'($urandom);
            cycle($urandom_range(0, 3) != 0, 1'($urandom), a, $urandom, 2'($urandom),
                  1'($urandom), $urandom_range(0, 3) != 0);
        end
        repeat (2) cycle(0, 0, 0, 0, 0, 0, 1);

        // Reset mid-operation: pending response dropped, presented store not written
        cycle(1, 0, 32'h44, 32'h0, 2'd2, 0, 0);
        rst = 1'b0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h44;
        req_wdata = ~model_mem[17]; req_size = 2'd2; rsp_ready = 1'b0;
        #1;
        check("rst_drop_valid", 32'(rsp_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("rst_hold_valid", 32'(rsp_valid), 32'd0);
        check("rst_hold_rdata", rsp_rdata, 32'd0);
        exp_q.delete();
        rst = 1'b1;
        cycle(1, 0, 32'h44, 32'h0, 2'd2, 0, 1);
        check("rst_no_write", rsp_rdata, model_mem[17]);
        repeat (2) cycle(0, 0, 0, 0, 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder serving load/store requests issued by the MEM stage; it is the memory end of the MEM stage's data access interface. It holds a byte-addressable, word-organised RAM, accepts one request per cycle under a valid/ready handshake, and returns one response per request. Load data is lane-aligned and sign- or zero-extended. Store data is written with byte enables. Returned load data goes straight to the MEM stage's write-back path.

## Interface
Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; must be a power of 2; the index width is log2(DEPTH_WORDS).

Ports:
- clk  in  1  clock.
- rst  in  1  reset. One clock; reset is asynchronous and active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low-order lanes are used for byte and halfword stores.
- req_size  in  2  access size: 00 byte, 01 halfword, 10 word; 11 is reserved.
- req_unsigned  in  1  zero-extend load data (LBU/LHU).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  32  extended load data; 0 for stores and for errors.
- rsp_error  out  1  the access was rejected.

## Operation
- A request is accepted on the clock edge where req_valid && req_ready.
- req_ready = !rsp_valid || rsp_ready. This is a single response slot with pass-through refill, giving full throughput.
- Word index = req_addr[log2(DEPTH_WORDS)+1:2]. Lane = req_addr[1:0].
- Store, accepted without error:
  - Written on the accept edge using byte enables.
  - Byte: 0001 shifted by lane; data is wdata[7:0] replicated to all lanes.
  - Halfword: 0011 shifted by lane; data is wdata[15:0] replicated.
  - Word: enables 1111.
- Load: synchronous read of the indexed word on the accept edge. Lane, size and unsigned are captured in the same edge.
- Response data:
  - Byte: selected byte, sign-extended from bit 7 unless unsigned.
  - Halfword: selected half (lane 0 or 2), sign-extended from bit 15 unless unsigned.
  - Word: full word.
- A store responds with rsp_rdata = 0 as its acknowledgement.
- Error conditions (only when DMEM_ERR_CHECK_EN is defined):
  - halfword with addr[0] = 1;
  - word with addr[1:0] != 0;
  - size 11;
  - addr[31:2] >= DEPTH_WORDS.
- An errored request:
  - produces a response with rsp_error = 1 and rsp_rdata = 0;
  - performs no write and does not alter memory.
- While rsp_valid && !rsp_ready, rsp_rdata and rsp_error hold stable. The RAM output is not re-read because no new request is accepted.
- There is no FSM beyond the rsp_valid slot flag: the two states are EMPTY and FULL.
  - EMPTY→FULL on accept.
  - FULL→EMPTY on rsp_ready with no accept.
  - FULL stays FULL on a simultaneous pop and accept.

## Timing
- Reset values: rsp_valid 0, rsp_error 0, rsp_rdata 0. req_ready is therefore 1 out of reset. RAM contents are not reset.
- Load latency: accept at edge N gives rsp_valid and data valid after edge N, i.e. in cycle N+1.
- Store: memory is updated at edge N. A load accepted at edge N+1 to the same address returns the new data.
- Store followed by a load in consecutive cycles needs no bubble.
- Read of a word written at the same edge is impossible, since only one request is accepted per edge.
- Reset asserted mid-operation:
  - any pending response is dropped;
  - a store presented at an edge while rst = 0 is not written.
- Deassertion of rst is assumed synchronised externally.

## Configuration
- DMEM_ERR_CHECK_EN defined: full misalignment, reserved-size and range checking as above.
- Not defined:
  - rsp_error is tied to 0;
  - the address wraps modulo DEPTH_WORDS*4;
  - misaligned halfword and word accesses force the lane to 0 (halfword uses addr[1] only);
  - size 11 is treated as word.

## Structure
- The shared core package/header holds:
  - size encodings MEM_SIZE_B/H/W;
  - DATA width, reused from the existing data range definition;
  - the byte-enable width constant.
- Sub-module dmem_sram contains:
  - a DEPTH_WORDS x 32 array;
  - a 4-bit byte-enable write port;
  - a registered read port.
- The top level holds the handshake, error checks, capture registers and the extract/extend logic.

## Test plan
- After reset: rsp_valid 0, req_ready 1, rsp_rdata 0.
- Store a word 0xDEADBEEF to 0x10, then LB at 0x13 → rsp_rdata 0xFFFFFFDE. LBU at 0x13 → 0x000000DE.
- SH 0x1234 to 0x22, then LW at 0x20 → upper half 0x1234, lower half unchanged. LH at 0x22 → 0x00001234.
- Hold rsp_ready = 0 for 3 cycles after a load:
  - req_ready is 0;
  - rsp_rdata is stable;
  - a pending store is not written until the cycle after rsp_ready rises.
- Back-to-back 8 loads with rsp_ready = 1 → 8 responses in 8 consecutive cycles, in order.
- With DMEM_ERR_CHECK_EN:
  - LW at 0x22 → rsp_error 1, rdata 0;
  - SW to DEPTH_WORDS*4 → rsp_error 1, memory unchanged.
- Without DMEM_ERR_CHECK_EN, the same SW wraps to word 0.
